// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Call-request scheduler that sits in front of the elevator movement state
// machine. It latches floor call buttons and picks the service order with a
// SCAN policy: the car keeps its current direction while calls remain ahead
// of it. It commands the movement FSM through stop_go/up_down, reads the
// floor back on cur_floor, and times the door-open dwell at each served floor.
//
// Optional feature: define SCHED_ESTOP_EN to add the estop input and a HALT
// state. HALT freezes motion and closes the door. Pending calls are kept, and
// new calls still latch while halted.
//
// Ports
//   CLK        in   1           single clock, rising edge
//   RST        in   1           synchronous reset, active-high
//   estop      in   1           emergency stop (SCHED_ESTOP_EN only)
//   call_req   in   NUM_FLOORS  call pulses, one bit per floor
//   cur_floor  in   FLOOR_W     floor reported by the movement FSM
//   stop_go    out  1           1 = move, 0 = hold
//   up_down    out  1           1 = up, 0 = down (current direction)
//   pending    out  NUM_FLOORS  latched outstanding calls
//   door_open  out  1           high during the dwell at a served floor
//   busy       out  1           high in any state other than IDLE
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef SCHED_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  stop_go,
  output logic                  up_down,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  busy
);

  localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);

`ifdef SCHED_ESTOP_EN
  typedef enum logic [1:0] {IDLE, MOVE, DOOR, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
`endif

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  stop_go_q, up_down_q, door_open_q, busy_q;

  // Per-floor masks relative to the car position. The masks are built from
  // the latched calls only, so a new call takes one edge to influence
  // direction choice.
  logic [NUM_FLOORS-1:0] cur_hit, above_mask, below_mask;

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign cur_hit[gi]    = (cur_floor == FLOOR_W'(gi));
      assign above_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) > cur_floor);
      assign below_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) < cur_floor);
    end
  endgenerate

  logic any_above, any_below, calls_ahead, calls_behind, floor_valid;
  assign any_above    = |above_mask;
  assign any_below    = |below_mask;
  assign calls_ahead  = dir_q ? any_above : any_below;
  assign calls_behind = dir_q ? any_below : any_above;
  assign floor_valid  = (int'(cur_floor) < NUM_FLOORS);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    pending_d = pending_q | call_req;

    case (state_q)
      IDLE: begin
        if (|(pending_q & cur_hit)) begin
          state_d   = DOOR;
          pending_d = pending_d & ~cur_hit;
          timer_d   = TIMER_LOAD;
        end else if (any_above && (dir_q || !any_below)) begin
          dir_d   = 1'b1;
          state_d = MOVE;
        end else if (any_below) begin
          dir_d   = 1'b0;
          state_d = MOVE;
        end
      end

      MOVE: begin
        if (!floor_valid) begin
          state_d = IDLE;
        end else if (|((pending_q | call_req) & cur_hit)) begin
          // A call arriving for the floor being passed is served at once,
          // so its set and clear collapse into nothing.
          state_d   = DOOR;
          pending_d = pending_d & ~cur_hit;
          timer_d   = TIMER_LOAD;
        end
      end

      DOOR: begin
        // Pressing the button of the floor we are standing at holds the door
        // open longer instead of queuing a call.
        pending_d = pending_q | (call_req & ~cur_hit);
        if (|(call_req & cur_hit)) begin
          timer_d = TIMER_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (calls_ahead) begin
          state_d = MOVE;
        end else if (calls_behind) begin
          dir_d   = ~dir_q;
          state_d = MOVE;
        end else begin
          state_d = IDLE;
        end
      end

`ifdef SCHED_ESTOP_EN
      HALT: begin
        if (!estop) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef SCHED_ESTOP_EN
    // An emergency stop overrides everything except reset. Nothing is served,
    // but calls keep latching.
    if (estop) begin
      state_d   = HALT;
      dir_d     = dir_q;
      timer_d   = '0;
      pending_d = pending_q | call_req;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      timer_q     <= '0;
      pending_q   <= '0;
      stop_go_q   <= 1'b0;
      up_down_q   <= 1'b1;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      // Moore outputs are registered from the next-state values, so they
      // line up with the state register.
      stop_go_q   <= (state_d == MOVE);
      up_down_q   <= dir_d;
      door_open_q <= (state_d == DOOR);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign stop_go   = stop_go_q;
  assign up_down   = up_down_q;
  assign pending   = pending_q;
  assign door_open = door_open_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for elevator_call_scheduler.
//
// A table of {inputs, expected outputs} records walks through several
// scenarios: reset, a single call, SCAN ordering, reversal at floor 0, a call
// collapsing at a passed floor, reversal at the top floor and reset while
// moving. Hand-written sequences then cover the door hold-open and, when
// SCHED_ESTOP_EN is defined, the emergency stop.
// -----------------------------------------------------------------------------
module tb_elevator_call_scheduler;

  localparam int NF = 4;
  localparam int FW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NF-1:0] call_req;
  logic [FW-1:0] cur_floor;
  logic          stop_go, up_down, door_open, busy;
  logic [NF-1:0] pending;
`ifdef SCHED_ESTOP_EN
  logic          estop;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  elevator_call_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .DOOR_CYCLES(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef SCHED_ESTOP_EN
    .estop    (estop),
`endif
    .call_req (call_req),
    .cur_floor(cur_floor),
    .stop_go  (stop_go),
    .up_down  (up_down),
    .pending  (pending),
    .door_open(door_open),
    .busy     (busy)
  );

  // exp packs {stop_go, up_down, pending[3:0], door_open, busy}
  typedef struct {
    logic       rst;
    logic [3:0] call;
    logic [1:0] fl;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [1:0] f,
                              input logic sg, input logic ud, input logic [3:0] p,
                              input logic d, input logic b);
    vec_t v;
    v.rst  = r;
    v.call = c;
    v.fl   = f;
    v.exp  = {sg, ud, p, d, b};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int door_cnt;
  logic saw_go;

  initial begin
    RST = 1'b1; call_req = '0; cur_floor = '0;
`ifdef SCHED_ESTOP_EN
    estop = 1'b0;
`endif
    //                rst call     fl  sg ud pend     dr bz
    // Reset held 3 clocks while every button is pressed
    vecs.push_back(mk(1, 4'b1111, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0));
    // Single call to floor 2 from floor 0
    vecs.push_back(mk(0, 4'b0100, 0, 0, 1, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 0, 0));
    // SCAN from floor 1 going up with calls at 3 and 0
    vecs.push_back(mk(0, 4'b1001, 1, 0, 1, 4'b1001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 4'b1001, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 1, 1, 4'b1001, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 3, 0, 1, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 3, 0, 1, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 3, 0, 1, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 3, 0, 1, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // Floor 0 with dir down and a call above: reverse to up
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0100, 0, 1));
    // A call for floor 1 arrives as the car passes it: served, never latched
    vecs.push_back(mk(0, 4'b0010, 1, 0, 1, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 2, 0, 1, 4'b0000, 0, 0));
    // Top floor, dir up, only a lower call: reverse
    vecs.push_back(mk(0, 4'b0001, 3, 0, 1, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 4'b0001, 0, 1));
    // Reset while moving, with a call pressed during reset: all dropped
    vecs.push_back(mk(1, 4'b1000, 3, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 3, 0, 1, 4'b0000, 0, 0));

    foreach (vecs[i]) begin
      RST       = vecs[i].rst;
      call_req  = vecs[i].call;
      cur_floor = vecs[i].fl;
      step();
      check($sformatf("vec%0d {sg,ud,pend,door,busy}", i),
            {24'd0, stop_go, up_down, pending, door_open, busy},
            {24'd0, vecs[i].exp});
    end

    // Same-floor call at floor 2, then the button again in door cycle 2
    RST = 1'b0; cur_floor = 2'd2; call_req = 4'b0100;
    step();
    check("same_floor_latch", {28'd0, pending}, 32'h4);
    call_req = 4'b0000;
    step();
    check("same_floor_door {sg,door}", {30'd0, stop_go, door_open}, 32'h1);
    step();
    check("door_cycle2", {31'd0, door_open}, 32'h1);
    call_req = 4'b0100;
    step();
    call_req = 4'b0000;
    door_cnt = 2;
    saw_go   = 1'b0;
    for (int i = 0; i < 20 && door_open; i++) begin
      door_cnt++;
      saw_go = saw_go | stop_go;
      step();
    end
    check("door_hold_len", door_cnt, 32'd6);
    check("door_hold_no_move", {31'd0, saw_go}, 32'h0);
    check("door_hold_not_latched {pend,busy}", {27'd0, pending, busy}, 32'h0);

`ifdef SCHED_ESTOP_EN
    // Emergency stop while moving up toward floor 3
    cur_floor = 2'd0; call_req = 4'b1000;
    step();
    call_req = 4'b0000;
    step();
    check("estop_pre_move", {31'd0, stop_go}, 32'h1);
    estop = 1'b1;
    step();
    check("estop_halt {sg,door,busy,pend}", {25'd0, stop_go, door_open, busy, pending}, 32'h18);
    call_req = 4'b0001;
    step();
    call_req = 4'b0000;
    check("estop_latch {sg,pend}", {27'd0, stop_go, pending}, 32'h9);
    estop = 1'b0; cur_floor = 2'd1;
    step();
    check("estop_release {sg,busy}", {30'd0, stop_go, busy}, 32'h0);
    step();
    check("estop_resume {sg,ud,pend}", {26'd0, stop_go, up_down, pending}, 32'h39);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
